fir_sample_loader: RTL

//  - Upstream feeder and sequencer for the FIR top level (fir_top).
//  - Accepts a byte stream over a valid/ready handshake.
//  - Writes the bytes into the shared BRAM input region, then issues one fir_start pulse.
//  - Waits for fir_done, then latches the FIR cycle counter and reports completion.
//  - A watchdog flags a FIR run that never finishes.

---
 rtl/fir_sample_loader_pkg.sv | 17 +
 rtl/fir_watchdog.sv | 31 +++
 rtl/fir_sample_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/fir_sample_loader_pkg.sv
// Shared definitions for the FIR sample loader: default widths and FSM state encoding.
package fir_sample_loader_pkg;

  localparam int unsigned ADDR_W_DEF  = 10;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 1000000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_KICK      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_FINISH    = 3'd4
  } state_t;

endpackage

// File: rtl/fir_watchdog.sv
// Loadable down-counter; expire_c flags the enabled cycle in which the count has reached zero.
module fir_watchdog #(
  parameter int unsigned W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire_c
);

  logic [W-1:0] count;

  // Clear beats load, load beats counting; the counter parks at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expire_c = en && (count == '0);

endmodule

// File: rtl/fir_sample_loader.sv
// Streams samples into the FIR input region of BRAM, kicks the FIR, and waits for it to finish.
module fir_sample_loader
  import fir_sample_loader_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              abort,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  output logic [ADDR_W-1:0] fir_input_addr,
  output logic [ADDR_W-1:0] fir_sample_count,
  output logic              fir_start,
  input  logic              fir_done,
  input  logic [CNT_W-1:0]  fir_cycles,
  output logic              busy,
  output logic              complete,
  output logic              timeout,
  output logic              err_len,
  output logic [CNT_W-1:0]  last_cycles
);

  localparam int unsigned WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] idx;
  logic              hs;
  logic              accept_arm;
  logic              reject_arm;
  logic              wr_fire;
  logic              done_hit;
  logic              wd_fire;
  logic              wait_first;
  logic              wd_load;
  logic              wd_en;
  logic              wd_expire_c;

  // Stream is only accepted while loading; this is the one combinational output.
  assign s_ready = (state == ST_LOAD);
  assign hs      = s_valid && s_ready;

  assign wd_load = (state == ST_KICK) && !abort;
  assign wd_en   = (state == ST_WAIT_DONE);

  // Loaded with TIMEOUT-1 on entry so expiry lands on the TIMEOUT-th WAIT_DONE cycle.
  fir_watchdog #(
    .W (WD_W)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (abort),
    .load     (wd_load),
    .load_val (WD_W'(TIMEOUT - 1)),
    .en       (wd_en),
    .expire_c (wd_expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and event strobes; abort overrides everything.
  always_comb begin
    state_next = state;
    accept_arm = 1'b0;
    reject_arm = 1'b0;
    wr_fire    = 1'b0;
    done_hit   = 1'b0;
    wd_fire    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arm) begin
          if (load_len != '0) begin
            accept_arm = 1'b1;
            state_next = ST_LOAD;
          end else begin
            reject_arm = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (hs) begin
          wr_fire = 1'b1;
          if (idx == fir_sample_count - ADDR_W'(1)) begin
            state_next = ST_KICK;
          end
        end
      end
      ST_KICK: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A stale done from the previous run is masked for one cycle; done beats the watchdog.
        if (fir_done && !wait_first) begin
          done_hit   = 1'b1;
          state_next = ST_FINISH;
        end else if (wd_expire_c) begin
          wd_fire    = 1'b1;
          state_next = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_next = ST_IDLE;
      accept_arm = 1'b0;
      reject_arm = 1'b0;
      wr_fire    = 1'b0;
      done_hit   = 1'b0;
      wd_fire    = 1'b0;
    end
  end

  // Registered datapath: write port, captured run parameters, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx              <= '0;
      bram_addr        <= '0;
      bram_din         <= '0;
      bram_we          <= 1'b0;
      fir_input_addr   <= '0;
      fir_sample_count <= '0;
      fir_start        <= 1'b0;
      busy             <= 1'b0;
      complete         <= 1'b0;
      timeout          <= 1'b0;
      err_len          <= 1'b0;
      last_cycles      <= '0;
      wait_first       <= 1'b0;
    end else begin
      bram_we    <= wr_fire;
      busy       <= (state_next != ST_IDLE);
      complete   <= (state_next == ST_FINISH);
      wait_first <= (state == ST_KICK);
      // Start follows KICK by a register stage, so it trails the last BRAM write.
      fir_start  <= (state == ST_KICK) && !abort;

      if (wr_fire) begin
        bram_addr <= fir_input_addr + idx;
        bram_din  <= s_data;
        idx       <= idx + ADDR_W'(1);
      end

      if (accept_arm) begin
        fir_input_addr   <= load_base;
        fir_sample_count <= load_len;
        idx              <= '0;
        timeout          <= 1'b0;
        err_len          <= 1'b0;
      end

      if (reject_arm) begin
        err_len <= 1'b1;
      end

      if (done_hit) begin
        last_cycles <= fir_cycles;
      end

      if (wd_fire) begin
        timeout <= 1'b1;
      end
    end
  end

endmodule
